// File: rtl/rr_output_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_output_arbiter_if
//   Bundle of the request/grant/credit signals between the input-buffer route
//   logic (master side) and one router output arbiter (slave side).
//
//   req        master->slave  per-input "flit valid for this output"
//   tail       master->slave  per-input "current flit is the packet tail"
//   credit_in  master->slave  downstream freed one buffer slot (pulse)
//   gnt        slave->master  one-hot owner of the output (registered)
//   fwd        slave->master  owner's flit crosses the crossbar this cycle
//   credit_cnt slave->master  credits currently available downstream
//   credit_err slave->master  sticky: credit returned while counter was full
// ---------------------------------------------------------------------------
interface rr_output_arbiter_if #(
  parameter int NUM_REQ = 5,
  parameter int CNT_W   = 3
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] tail;
  logic               credit_in;
  logic [NUM_REQ-1:0] gnt;
  logic               fwd;
  logic [CNT_W-1:0]   credit_cnt;
  logic               credit_err;

  modport master (
    output req, tail, credit_in,
    input  gnt, fwd, credit_cnt, credit_err
  );

  modport slave (
    input  req, tail, credit_in,
    output gnt, fwd, credit_cnt, credit_err
  );
endinterface

// File: rtl/rr_output_arbiter.sv
// ---------------------------------------------------------------------------
// rr_output_arbiter
//   Per-output-port packet arbiter for a mesh router. Grants one input port
//   at a time and holds the grant from head flit to tail flit, so packets
//   never interleave on the output link. Requesters are served round-robin:
//   the owner just released becomes the lowest priority. A downstream credit
//   counter stops forwarding when the neighbour's buffer is full.
//
//   Ports
//     clk  in  rising-edge clock for all state
//     rst  in  synchronous, active-high reset
//     bus  slave modport of rr_output_arbiter_if (req/tail/credit_in in,
//          gnt/fwd/credit_cnt/credit_err out)
//
//   Parameters
//     NUM_REQ  number of requesting input ports
//     CREDITS  downstream buffer depth in flits (credit counter reset value)
//     CNT_W    credit counter width; 2**CNT_W must exceed CREDITS
// ---------------------------------------------------------------------------
module rr_output_arbiter #(
  parameter int NUM_REQ = 5,
  parameter int CREDITS = 4,
  parameter int CNT_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  rr_output_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state_reg;
  logic [NUM_REQ-1:0] gnt_reg;
  logic [PTR_W-1:0]   ptr_reg;
  logic [CNT_W-1:0]   credit_cnt_reg;
  logic               credit_err_reg;

  logic [CNT_W-1:0]   credit_cnt_next;
  logic               credit_err_next;

  // -------------------------------------------------------------------------
  // Owner view: since gnt_reg is one-hot or zero, AND-ing it with req/tail
  // and OR-reducing yields the owner's req/tail without an index decode.
  // -------------------------------------------------------------------------
  logic [NUM_REQ-1:0] owner_req_vec;
  logic [NUM_REQ-1:0] owner_tail_vec;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_owner
      assign owner_req_vec[gi]  = gnt_reg[gi] & bus.req[gi];
      assign owner_tail_vec[gi] = gnt_reg[gi] & bus.tail[gi];
    end
  endgenerate

  logic owner_req;
  logic owner_tail;
  logic credit_avail;
  logic fwd_c;
  logic release_c;

  assign owner_req    = |owner_req_vec;
  assign owner_tail   = |owner_tail_vec;
  assign credit_avail = (credit_cnt_reg != '0);

  // fwd is combinational from the registered grant so the first flit can
  // move in the same cycle the grant appears.
  assign fwd_c     = (state_reg == LOCKED) & owner_req & credit_avail;
  assign release_c = fwd_c & owner_tail;

  // -------------------------------------------------------------------------
  // Round-robin pick: scan ptr, ptr+1, ..., wrapping, and take the first
  // requester. Only consumed in IDLE.
  // -------------------------------------------------------------------------
  logic [NUM_REQ-1:0] pick_onehot;
  logic               pick_found;
  logic [PTR_W-1:0]   cand;

  always_comb begin
    pick_onehot = '0;
    pick_found  = 1'b0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(ptr_reg) + k) % NUM_REQ);
      if (!pick_found && bus.req[cand]) begin
        pick_onehot[cand] = 1'b1;
        pick_found        = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Owner index and the pointer value that makes it lowest priority next.
  // -------------------------------------------------------------------------
  logic [PTR_W-1:0] owner_idx;
  logic [PTR_W-1:0] ptr_next;

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_reg[i]) begin
        owner_idx = PTR_W'(i);
      end
    end
  end

  assign ptr_next = (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + 1'b1;

  // -------------------------------------------------------------------------
  // Credit counter. A forwarded flit and a returned credit in the same
  // cycle cancel. A credit returned while already full is a protocol error
  // from downstream: the count is held and the sticky error flag is raised.
  // -------------------------------------------------------------------------
  always_comb begin
    credit_cnt_next = credit_cnt_reg;
    credit_err_next = credit_err_reg;
    case ({fwd_c, bus.credit_in})
      2'b10: credit_cnt_next = credit_cnt_reg - 1'b1;
      2'b01: begin
        if (credit_cnt_reg == CNT_W'(CREDITS)) begin
          credit_err_next = 1'b1;
        end else begin
          credit_cnt_next = credit_cnt_reg + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Arbitration FSM and credit state.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      gnt_reg        <= '0;
      ptr_reg        <= '0;
      credit_cnt_reg <= CNT_W'(CREDITS);
      credit_err_reg <= 1'b0;
    end else begin
      credit_cnt_reg <= credit_cnt_next;
      credit_err_reg <= credit_err_next;
      case (state_reg)
        IDLE: begin
          // Credits are deliberately not checked here: the grant is taken
          // and forwarding simply waits in LOCKED until a credit exists.
          if (pick_found) begin
            gnt_reg   <= pick_onehot;
            state_reg <= LOCKED;
          end
        end
        LOCKED: begin
          // Hold ownership through bubbles (owner req low) until the tail
          // flit is actually forwarded.
          if (release_c) begin
            gnt_reg   <= '0;
            ptr_reg   <= ptr_next;
            state_reg <= IDLE;
          end
        end
        default: begin
          gnt_reg   <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt        = gnt_reg;
  assign bus.fwd        = fwd_c;
  assign bus.credit_cnt = credit_cnt_reg;
  assign bus.credit_err = credit_err_reg;

endmodule

// File: tb/tb_rr_output_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_output_arbiter
//   Directed bench for rr_output_arbiter. Inputs change 1 time unit after
//   the rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_rr_output_arbiter;

  localparam int NUM_REQ = 5;
  localparam int CREDITS = 4;
  localparam int CNT_W   = 3;

  logic clk;
  logic rst;

  int n_checks;
  int n_pass;

  rr_output_arbiter_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();

  rr_output_arbiter #(
    .NUM_REQ(NUM_REQ),
    .CREDITS(CREDITS),
    .CNT_W  (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("[%0t] ok   %s: got %0h want %0h", $time, tag, obs, exp);
    end else begin
      $display("[%0t] FAIL %s: got %0h want %0h", $time, tag, obs, exp);
    end
  endtask

  // advance to the next cycle's input-drive point
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    int exp_idx;
    n_checks = 0;
    n_pass   = 0;

    // ---------------- reset ----------------
    rst = 1'b1;
    bus.req = '0;
    bus.tail = '0;
    bus.credit_in = 1'b0;
    step();
    step();
    sample();
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_fwd", 32'(bus.fwd), 32'h0);
    chk("rst_cnt", 32'(bus.credit_cnt), 32'd4);
    chk("rst_err", 32'(bus.credit_err), 32'h0);
    step();
    rst = 1'b0;

    // ---------------- 1: single-flit packet from input 2 ----------------
    bus.req = 5'b00100; bus.tail = 5'b00100;
    sample();
    chk("t1_idle_gnt", 32'(bus.gnt), 32'h0);
    step();
    sample();
    chk("t1_gnt", 32'(bus.gnt), 32'h04);
    chk("t1_fwd", 32'(bus.fwd), 32'h1);
    step();
    bus.req = '0; bus.tail = '0;
    sample();
    chk("t1_rel_gnt", 32'(bus.gnt), 32'h0);
    chk("t1_cnt", 32'(bus.credit_cnt), 32'd3);

    // ---------------- 2: all request, single flits, 10 grants ----------------
    // ptr was left at 3, so the order is 3,4,0,1,2,3,...
    for (int k = 0; k < 10; k++) begin
      step();
      bus.req = 5'b11111; bus.tail = 5'b11111; bus.credit_in = 1'b0;
      sample();
      chk($sformatf("t2_idle%0d", k), 32'(bus.gnt), 32'h0);
      step();
      bus.credit_in = 1'b1; // returned in the forward cycle: count stays put
      exp_idx = (3 + k) % NUM_REQ;
      sample();
      chk($sformatf("t2_gnt%0d", k), 32'(bus.gnt), 32'(1 << exp_idx));
      chk($sformatf("t2_fwd%0d", k), 32'(bus.fwd), 32'h1);
    end
    step();
    bus.req = '0; bus.tail = '0; bus.credit_in = 1'b0;
    sample();
    chk("t2_end_gnt", 32'(bus.gnt), 32'h0);
    chk("t2_end_cnt", 32'(bus.credit_cnt), 32'd3);

    // ---------------- 3: 3-flit packet from input 1 with a 2-cycle bubble ----
    // ptr=3 now; input 1 requests alone first, input 0 joins after the grant.
    step();
    bus.req = 5'b00010; bus.tail = '0;
    sample();
    chk("t3_c0_gnt", 32'(bus.gnt), 32'h0);
    step();
    bus.req = 5'b00011;
    sample();
    chk("t3_c1_gnt", 32'(bus.gnt), 32'h02);
    chk("t3_c1_fwd", 32'(bus.fwd), 32'h1);
    for (int k = 0; k < 2; k++) begin
      step();
      bus.req = 5'b00001;
      sample();
      chk($sformatf("t3_gap%0d_gnt", k), 32'(bus.gnt), 32'h02);
      chk($sformatf("t3_gap%0d_fwd", k), 32'(bus.fwd), 32'h0);
    end
    step();
    bus.req = 5'b00011; bus.tail = '0;
    sample();
    chk("t3_c4_gnt", 32'(bus.gnt), 32'h02);
    chk("t3_c4_fwd", 32'(bus.fwd), 32'h1);
    step();
    bus.tail = 5'b00010;
    sample();
    chk("t3_c5_gnt", 32'(bus.gnt), 32'h02);
    chk("t3_c5_fwd", 32'(bus.fwd), 32'h1);
    step();
    bus.req = 5'b00001; bus.tail = '0;
    sample();
    chk("t3_c6_gnt", 32'(bus.gnt), 32'h0);
    chk("t3_c6_cnt", 32'(bus.credit_cnt), 32'd0);
    // input 0 is granted with no credits; forwarding waits for credit_in
    step();
    bus.tail = 5'b00001; bus.credit_in = 1'b1;
    sample();
    chk("t3_c7_gnt", 32'(bus.gnt), 32'h01);
    chk("t3_c7_fwd", 32'(bus.fwd), 32'h0);
    step();
    bus.credit_in = 1'b0;
    sample();
    chk("t3_c8_fwd", 32'(bus.fwd), 32'h1);
    chk("t3_c8_cnt", 32'(bus.credit_cnt), 32'd1);
    step();
    bus.req = '0; bus.tail = '0;
    sample();
    chk("t3_c9_gnt", 32'(bus.gnt), 32'h0);
    // refill to full
    bus.credit_in = 1'b1;
    repeat (4) step();
    bus.credit_in = 1'b0;
    sample();
    chk("refill_cnt", 32'(bus.credit_cnt), 32'd4);
    chk("refill_err", 32'(bus.credit_err), 32'h0);

    // ---------------- 4: credit exhaustion from one owner ----------------
    // ptr=1: input 2 wins
    step();
    bus.req = 5'b00100; bus.tail = '0;
    sample();
    chk("t4_idle_gnt", 32'(bus.gnt), 32'h0);
    for (int k = 0; k < 6; k++) begin
      step();
      sample();
      chk($sformatf("t4_fwd%0d", k), 32'(bus.fwd), (k < 4) ? 32'h1 : 32'h0);
      chk($sformatf("t4_cnt%0d", k), 32'(bus.credit_cnt), (k < 4) ? 32'(4 - k) : 32'd0);
    end
    step();
    bus.credit_in = 1'b1;
    sample();
    chk("t4_cin_fwd", 32'(bus.fwd), 32'h0);
    step();
    bus.credit_in = 1'b0;
    sample();
    chk("t4_after_cin_fwd", 32'(bus.fwd), 32'h1);
    chk("t4_after_cin_cnt", 32'(bus.credit_cnt), 32'd1);
    step();
    sample();
    chk("t4_dry_fwd", 32'(bus.fwd), 32'h0);
    chk("t4_dry_gnt", 32'(bus.gnt), 32'h04);

    // ---------------- 5: fwd + credit_in together, then overflow ----------
    bus.credit_in = 1'b1;
    step();
    bus.tail = 5'b00100; // credit_in still 1: fwd and credit_in coincide
    sample();
    chk("t5_both_fwd", 32'(bus.fwd), 32'h1);
    chk("t5_both_cnt_before", 32'(bus.credit_cnt), 32'd1);
    step();
    bus.req = '0; bus.tail = '0; bus.credit_in = 1'b0;
    sample();
    chk("t5_both_cnt_after", 32'(bus.credit_cnt), 32'd1);
    chk("t5_rel_gnt", 32'(bus.gnt), 32'h0);
    bus.credit_in = 1'b1;
    repeat (3) step();
    bus.credit_in = 1'b0;
    sample();
    chk("t5_full_cnt", 32'(bus.credit_cnt), 32'd4);
    chk("t5_full_err", 32'(bus.credit_err), 32'h0);
    bus.credit_in = 1'b1;
    step();
    bus.credit_in = 1'b0;
    sample();
    chk("t5_ovf_cnt", 32'(bus.credit_cnt), 32'd4);
    chk("t5_ovf_err", 32'(bus.credit_err), 32'h1);
    repeat (3) step();
    sample();
    chk("t5_err_sticky", 32'(bus.credit_err), 32'h1);

    // ---------------- 6: reset while LOCKED mid-packet ----------------
    // ptr=3: input 3 wins; three flits take credits 4 -> 1
    bus.req = 5'b01000; bus.tail = '0;
    step();
    for (int k = 0; k < 3; k++) begin
      sample();
      chk($sformatf("t6_fwd%0d", k), 32'(bus.fwd), 32'h1);
      step();
    end
    sample();
    chk("t6_locked_gnt", 32'(bus.gnt), 32'h08);
    chk("t6_locked_cnt", 32'(bus.credit_cnt), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req = 5'b11111;
    sample();
    chk("t6_rst_gnt", 32'(bus.gnt), 32'h0);
    chk("t6_rst_fwd", 32'(bus.fwd), 32'h0);
    chk("t6_rst_cnt", 32'(bus.credit_cnt), 32'd4);
    chk("t6_rst_err", 32'(bus.credit_err), 32'h0);
    step();
    sample();
    chk("t6_ptr0_gnt", 32'(bus.gnt), 32'h01);
    bus.req = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
